// File: rtl/cam_frame_writer.sv
// Camera capture: pairs RGB565 bytes from a vsync/href camera bus into pixels and
// writes them to a linear frame buffer, flagging frames with bad geometry.
module cam_frame_writer #(
  parameter int unsigned H_PIX   = 320,
  parameter int unsigned V_LINES = 240,
  parameter int unsigned ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned XW = $clog2(H_PIX + 1);
  localparam int unsigned YW = $clog2(V_LINES + 1);

  typedef enum logic [1:0] {
    StWaitVsHigh,
    StWaitVsLow,
    StActive
  } state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic              href_q, href_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    href_d  = 1'b0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      StWaitVsHigh: begin
        if (cam_vsync) state_d = StWaitVsLow;
      end

      StWaitVsLow: begin
        if (!cam_vsync && capture_en) begin
          state_d = StActive;
          x_d     = '0;
          y_d     = '0;
          base_d  = '0;
          phase_d = 1'b0;
          err_d   = 1'b0;
        end
      end

      StActive: begin
        // href history only tracked while active so a stale high never fakes a line end
        href_d = cam_href;
        if (cam_vsync) begin
          state_d = StWaitVsLow;
          done_d  = 1'b1;
          phase_d = 1'b0;
          if (y_q != YW'(V_LINES)) err_d = 1'b1;
        end else if (cam_href) begin
          if (!phase_q) begin
            hi_d    = cam_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (x_q < XW'(H_PIX) && y_q < YW'(V_LINES)) begin
              we_d    = 1'b1;
              wdata_d = {hi_q, cam_data};
              waddr_d = base_q + ADDR_W'(x_q);
              x_d     = x_q + XW'(1);
            end else begin
              // x sticks at H_PIX so overlong lines cannot wrap the counter
              err_d = 1'b1;
            end
          end
        end else if (href_q) begin
          if (x_q != XW'(H_PIX) || phase_q) err_d = 1'b1;
          phase_d = 1'b0;
          x_d     = '0;
          if (y_q < YW'(V_LINES)) begin
            y_d    = y_q + YW'(1);
            base_d = base_q + ADDR_W'(H_PIX);
          end
        end
      end

      default: state_d = StWaitVsHigh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWaitVsHigh;
      x_q     <= '0;
      y_q     <= '0;
      base_q  <= '0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      href_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      href_q  <= href_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign we         = we_q;
  assign wAddr      = waddr_q;
  assign wData      = wdata_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: doc/cam_frame_writer.md
CAM_FRAME_WRITER -- requirements
Module: cam_frame_writer

Interface
REQ-001 SHALL have parameter H_PIX, default 320: pixels per line written to the frame buffer.
REQ-002 SHALL have parameter V_LINES, default 240: lines per frame written to the frame buffer.
REQ-003 SHALL have parameter ADDR_W, default 17: width of the frame-buffer address.
REQ-004 SHALL have port clk  input  1  single clock; all inputs are synchronous to it.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cam_vsync  input  1  high = vertical blanking; the rising edge ends a frame.
REQ-007 SHALL have port cam_href  input  1  high = cam_data carries a valid line byte this cycle.
REQ-008 SHALL have port cam_data  input  8  camera byte stream, RGB565, high byte first.
REQ-009 SHALL have port capture_en  input  1  arms capture of the next frame.
REQ-010 SHALL have port we  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-011 SHALL have port wAddr  output  ADDR_W  frame-buffer write address.
REQ-012 SHALL have port wData  output  16  RGB565 pixel.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at the end of a captured frame.
REQ-014 SHALL have port frame_err  output  1  geometry error flag for the last captured frame.

Function
REQ-015 SHALL implement FSM states WAIT_VS_HIGH, WAIT_VS_LOW and ACTIVE.
REQ-016 SHALL move WAIT_VS_HIGH -> WAIT_VS_LOW when cam_vsync=1.
REQ-017 SHALL move WAIT_VS_LOW -> ACTIVE when cam_vsync=0 and capture_en=1.
  - On this transition, clear x, y, line base, byte phase and frame_err.
REQ-018 SHALL sample capture_en only in WAIT_VS_LOW; deasserting it mid-frame does not stop the current frame.
REQ-019 SHALL move ACTIVE -> WAIT_VS_LOW when cam_vsync=1.
  - Pulse frame_done for exactly one cycle on this transition.
  - Discard any pending high byte.
REQ-020 SHALL ignore cam_href and cam_data outside ACTIVE.
REQ-021 SHALL pair bytes in ACTIVE on each cycle with cam_href=1.
  - Phase 0: latch the high byte.
  - Phase 1: form the pixel {hi, lo}.
  - Toggle the phase after each byte.
REQ-022 SHALL assert we one cycle after the low byte is sampled (latency 1).
  - wData = {hi, lo}.
  - wAddr = y*H_PIX + x, computed as line base + x; the line base increments by H_PIX per line (no multiplier).
  - x then increments by 1.
REQ-023 SHALL hold we=0 on every other cycle; wAddr and wData hold their last values.
REQ-024 SHALL suppress the write when x >= H_PIX or y >= V_LINES and set frame_err.
REQ-025 SHALL treat a cam_href falling edge (1 last cycle, 0 now) in ACTIVE as end of line.
  - If x != H_PIX, set frame_err.
  - If phase = 1, discard the odd byte, reset the phase and set frame_err.
  - Reset x to 0.
  - Increment y and add H_PIX to the line base, saturating y at V_LINES.
REQ-026 SHALL set frame_err at frame end when y != V_LINES.
  - frame_err is valid when frame_done pulses.
  - frame_err holds until the next WAIT_VS_LOW -> ACTIVE transition.
REQ-027 SHALL end the frame per REQ-019 if cam_vsync rises while cam_href=1, without a line-end error for that partial line beyond REQ-026.
REQ-028 SHALL contain no combinational path from any input to any output; all outputs are registered.

Reset
REQ-029 SHALL, on reset=1 at a clk edge, enter WAIT_VS_HIGH and clear everything on the next cycle.
  - Outputs: we=0, wAddr=0, wData=0, frame_done=0, frame_err=0.
  - Internal: x=0, y=0, phase=0, line base=0.
REQ-030 SHALL take effect immediately on reset mid-frame; capture resumes only after a full cam_vsync high->low sequence.

Verification
REQ-031 SHALL cover: full 320x240 frame with the pixel value = index -> 76800 we pulses, addresses 0..76799 in order, one frame_done, frame_err=0.
REQ-032 SHALL cover: first bytes 0xAB, 0xCD on line 0 -> we=1 one cycle after 0xCD, wData=0xABCD, wAddr=0.
REQ-033 SHALL cover: line 5 carries 321 pixels -> 320 writes (last wAddr 1919), 321st dropped, line 6 starts at wAddr 1920, frame_err=1 at frame_done.
REQ-034 SHALL cover: line 0 carries 641 bytes -> 320 writes, odd byte discarded, line 1 first wAddr=320, frame_err=1.
REQ-035 SHALL cover: reset mid-frame at line 100, then cam_vsync low only -> we=0 from the cycle after reset, no writes until vsync goes high then low.
REQ-036 SHALL cover: capture_en=0 at frame start -> no writes and no frame_done for that frame; capture_en=1 before the next frame start -> that frame is captured normally.
